// File: rtl/gf2m_pkg.sv
// rtl/gf2m_pkg.sv - shared encodings and sizing helpers for the digit-serial GF(2^m) multiplier
package gf2m_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_MUL = 2'b00;
    localparam logic [1:0] MODE_SQR = 2'b01;
    localparam logic [1:0] MODE_MAC = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    // Number of digit cycles: ceil(width / d).
    function automatic int calc_n(input int width, input int d);
        return (width + d - 1) / d;
    endfunction

    // Counter width ceil(log2(n+1)) so the counter can also hold the value n.
    function automatic int calc_cw(input int n);
        int w;
        w = 1;
        while ((1 << w) < (n + 1)) w++;
        return w;
    endfunction

endpackage

// File: rtl/gf2m_mulx_reduce.sv
// rtl/gf2m_mulx_reduce.sv - combinational p * x^SHIFT mod f(x) with a single reduction fold
module gf2m_mulx_reduce #(
    parameter int WIDTH = 101,
    parameter int K3    = 7,
    parameter int K2    = 6,
    parameter int K1    = 1,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] q
);

    if (SHIFT < 0 || SHIFT > WIDTH - K3) begin : g_bad_shift
        $error("gf2m_mulx_reduce: SHIFT out of single-fold range");
    end

    if (SHIFT == 0) begin : g_pass
        assign q = p;
    end else begin : g_fold
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;

        // Coefficients pushed past x^(WIDTH-1) fold back via x^WIDTH = x^K3+x^K2+x^K1+1.
        assign lo = p << SHIFT;
        assign hi = p >> (WIDTH - SHIFT);
        assign q  = lo ^ hi ^ (hi << K1) ^ (hi << K2) ^ (hi << K3);
    end

endmodule

// File: rtl/gf2m_digit_mul.sv
// rtl/gf2m_digit_mul.sv - digit-serial GF(2^m) multiplier with square and multiply-accumulate modes
module gf2m_digit_mul
    import gf2m_pkg::*;
#(
    parameter int WIDTH = 101,
    parameter int D     = 16,
    parameter int K3    = 7,
    parameter int K2    = 6,
    parameter int K1    = 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] op_c,
    output logic             busy
);

    localparam int N  = calc_n(WIDTH, D);
    localparam int PW = N * D;
    localparam int CW = calc_cw(N);

    if (D < 1 || D > WIDTH - K3) begin : g_bad_digit
        $error("gf2m_digit_mul: D must lie in 1..WIDTH-K3");
    end
    if (!(WIDTH > K3 && K3 > K2 && K2 > K1 && K1 > 0)) begin : g_bad_poly
        $error("gf2m_digit_mul: pentanomial exponents must be strictly decreasing and positive");
    end

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [PW-1:0]    a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] cin_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] res_q;

    logic [D-1:0]     digit;
    logic [WIDTH-1:0] bx [D];
    logic [WIDTH-1:0] c_sh;
    logic [WIDTH-1:0] c_nxt;
    logic [WIDTH-1:0] c_fin;
    logic             last_digit;

    assign digit      = a_q[PW-1 -: D];
    assign last_digit = (cnt_q == CW'(N - 1));

    // Precomputed b*x^j mod f for every bit position of a digit.
    for (genvar j = 0; j < D; j++) begin : g_bx
        gf2m_mulx_reduce #(
            .WIDTH (WIDTH),
            .K3    (K3),
            .K2    (K2),
            .K1    (K1),
            .SHIFT (j)
        ) u_bx (
            .p (b_q),
            .q (bx[j])
        );
    end

    gf2m_mulx_reduce #(
        .WIDTH (WIDTH),
        .K3    (K3),
        .K2    (K2),
        .K1    (K1),
        .SHIFT (D)
    ) u_cx (
        .p (c_q),
        .q (c_sh)
    );

    always_comb begin
        c_nxt = c_sh;
        for (int j = 0; j < D; j++) begin
            if (digit[j]) c_nxt = c_nxt ^ bx[j];
        end
        c_fin = c_nxt;
        if (last_digit && mode_q == MODE_MAC) c_fin = c_nxt ^ cin_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)   state_d = ST_RUN;
            ST_RUN:  if (last_digit) state_d = ST_DONE;
            ST_DONE: if (out_ready)  state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    assign op_c = res_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= '0;
            mode_q  <= MODE_MUL;
            c_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q    <= PW'(op_a);
                        b_q    <= (mode == MODE_SQR) ? op_a : op_b;
                        cin_q  <= op_c_in;
                        mode_q <= mode;
                        cnt_q  <= '0;
                        c_q    <= '0;
                    end
                end
                ST_RUN: begin
                    // Most-significant digit leaves the top of a_q each cycle.
                    a_q   <= a_q << D;
                    c_q   <= c_fin;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_digit) res_q <= c_fin;
                end
                default: ;
            endcase
        end
    end

endmodule
